// File: rtl/shift_pkg.sv
// shift_pkg: shared types for the pipelined barrel shifter.
// Holds the shift-mode encoding used by every stage.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one barrel-shift level (shift by 2**LEVEL)
// followed by its pipeline register and valid/ready handshake.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     up_valid_i,
  output logic                     up_ready_o,
  input  logic [WIDTH-1:0]         up_data_i,
  input  logic [$clog2(WIDTH)-1:0] up_amt_i,
  input  shift_op_e                up_op_i,
  output logic                     dn_valid_o,
  input  logic                     dn_ready_i,
  output logic [WIDTH-1:0]         dn_data_o,
  output logic [$clog2(WIDTH)-1:0] dn_amt_o,
  output shift_op_e                dn_op_o
);

  localparam int AW = $clog2(WIDTH);
  localparam int S  = 1 << LEVEL;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shifted;
  logic [AW-1:0]    amt_q;
  shift_op_e        op_q;
  logic             load;

  // Shift by this level's weight; pass through when its amount bit is 0.
  always_comb begin
    shifted = up_data_i;
    unique case (up_op_i)
      OP_SLL: shifted = up_data_i << S;
      OP_SRL: shifted = up_data_i >> S;
      OP_SRA: shifted = $signed(up_data_i) >>> S;
      OP_ROR: shifted = {up_data_i[S-1:0], up_data_i[WIDTH-1:S]};
      default: shifted = up_data_i;
    endcase
    data_d = up_amt_i[LEVEL] ? shifted : up_data_i;
  end

  // Load when empty or when the downstream side takes our content.
  assign load       = ~valid_q | dn_ready_i;
  assign up_ready_o = load;

  // Pipeline register: valid always follows upstream on a load,
  // the payload only updates when a real request arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_SLL;
    end else if (load) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= data_d;
        amt_q  <= up_amt_i;
        op_q   <= up_op_i;
      end
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_amt_o   = amt_q;
  assign dn_op_o    = op_q;

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: LOG2W-deep pipelined barrel shifter
// (SLL/SRL/SRA/ROR) with valid/ready flow control.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    logic             up_vld;
    logic             up_rdy;
    logic             dn_rdy;
    logic             vld;
    logic [WIDTH-1:0] up_dat;
    logic [WIDTH-1:0] dat;
    logic [LOG2W-1:0] up_amt;
    logic [LOG2W-1:0] amt;
    shift_op_e        up_op;
    shift_op_e        op;

    if (k == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_dat = in_a;
      assign up_amt = in_b[LOG2W-1:0];
      assign up_op  = shift_op_e'(in_op);
    end else begin : g_link
      assign up_vld = g_lvl[k-1].vld;
      assign up_dat = g_lvl[k-1].dat;
      assign up_amt = g_lvl[k-1].amt;
      assign up_op  = g_lvl[k-1].op;
    end

    if (k == LOG2W - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_lvl[k+1].up_rdy;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .LEVEL (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid_i (up_vld),
      .up_ready_o (up_rdy),
      .up_data_i  (up_dat),
      .up_amt_i   (up_amt),
      .up_op_i    (up_op),
      .dn_valid_o (vld),
      .dn_ready_i (dn_rdy),
      .dn_data_o  (dat),
      .dn_amt_o   (amt),
      .dn_op_o    (op)
    );
  end

  assign in_ready   = g_lvl[0].up_rdy;
  assign out_valid  = g_lvl[LOG2W-1].vld;
  assign out_result = g_lvl[LOG2W-1].dat;

  // Upper amount bits and the tail stage's amount/op are not needed.
  logic unused_bits;
  assign unused_bits = ^{in_b[WIDTH-1:LOG2W],
                         g_lvl[LOG2W-1].amt,
                         g_lvl[LOG2W-1].op};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed bench for shift_pipe at WIDTH=32 and 8.
// Checks latency, modes, streaming, back-pressure and reset.
module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v_i, r_o, ov, ordy;
  logic [31:0] a, b, res;
  logic [1:0]  op;

  logic        v8, r8, ov8, ordy8;
  logic [7:0]  a8, b8, res8;
  logic [1:0]  op8;

  shift_pipe #(.WIDTH(32)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v_i),
    .in_ready   (r_o),
    .in_a       (a),
    .in_b       (b),
    .in_op      (op),
    .out_valid  (ov),
    .out_ready  (ordy),
    .out_result (res)
  );

  shift_pipe #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v8),
    .in_ready   (r8),
    .in_a       (a8),
    .in_b       (b8),
    .in_op      (op8),
    .out_valid  (ov8),
    .out_ready  (ordy8),
    .out_result (res8)
  );

  int passed = 0;
  int total  = 0;
  int acc    = 0;
  int got    = 0;
  int cyc_n  = 0;
  int acc_first = -1;
  int out_first = -1;
  int out_last  = -1;
  logic [31:0] expq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model32(input logic [31:0] x,
                                          input logic [31:0] s,
                                          input logic [1:0]  m);
    int n;
    n = int'(s[4:0]);
    case (m)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return $signed(x) >>> n;
      default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endcase
  endfunction

  // One clock of the streaming scoreboard; entered and left at posedge+1.
  task automatic cycle();
    #1;
    if (v_i && r_o) begin
      expq.push_back(model32(a, b, op));
      if (acc_first < 0) acc_first = cyc_n;
      acc++;
    end
    if (ov && !ordy && expq.size() > 0)
      chk("hold result", res, expq[0]);
    if (ov && ordy) begin
      if (out_first < 0) out_first = cyc_n;
      out_last = cyc_n;
      got++;
      if (expq.size() > 0) chk("stream result", res, expq.pop_front());
      else chk("spurious out_valid", ov, 0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic send32(input string tag, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [1:0] iop,
                        input logic [31:0] exp);
    a = ia; b = ib; op = iop; v_i = 1'b1; ordy = 1'b1;
    #1;
    chk({tag, " in_ready"}, r_o, 1);
    @(posedge clk);
    #1;
    v_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk({tag, " early valid"}, ov, 0);
      @(posedge clk);
      #1;
    end
    chk({tag, " valid"}, ov, 1);
    chk(tag, res, exp);
    @(posedge clk);
    #1;
    chk({tag, " drained"}, ov, 0);
  endtask

  task automatic send8(input string tag, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [1:0] iop,
                       input logic [7:0] exp);
    a8 = ia; b8 = ib; op8 = iop; v8 = 1'b1; ordy8 = 1'b1;
    #1;
    chk({tag, " in_ready"}, r8, 1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    for (int i = 1; i < 3; i++) begin
      chk({tag, " early valid"}, ov8, 0);
      @(posedge clk);
      #1;
    end
    chk({tag, " valid"}, ov8, 1);
    chk(tag, res8, exp);
    @(posedge clk);
    #1;
    chk({tag, " drained"}, ov8, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b1;
    v_i = 0; a = 0; b = 0; op = 0; ordy = 1;
    v8 = 0; a8 = 0; b8 = 0; op8 = 0; ordy8 = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", ov, 0);
    chk("reset out_result", res, 0);
    chk("reset out_valid w8", ov8, 0);
    chk("reset out_result w8", res8, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", r_o, 1);
    chk("in_ready after reset w8", r8, 1);

    send32("sra msb by 31", 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF);
    send32("srl msb by 31", 32'h8000_0000, 32'd31, 2'b01, 32'h0000_0001);
    send32("ror f1 by 4", 32'h0000_00F1, 32'd4, 2'b11, 32'h1000_000F);
    send32("sll upper ignored", 32'h0000_0001, 32'h25, 2'b00, 32'h0000_0020);
    send32("sra amount 0", 32'h8000_0001, 32'h20, 2'b10, 32'h8000_0001);
    send32("ror by 1", 32'h0000_0003, 32'd1, 2'b11, 32'h8000_0001);

    send8("w8 sra 90 by 3", 8'h90, 8'd3, 2'b10, 8'hF2);
    send8("w8 sll amt 0", 8'hA5, 8'h00, 2'b00, 8'hA5);
    send8("w8 srl amt 0", 8'hA5, 8'h00, 2'b01, 8'hA5);
    send8("w8 sra amt 0", 8'hA5, 8'h08, 2'b10, 8'hA5);
    send8("w8 ror amt 0", 8'hA5, 8'hF8, 2'b11, 8'hA5);

    // Back-to-back stream with the consumer always ready.
    ordy = 1; acc = 0; got = 0; cyc_n = 0;
    acc_first = -1; out_first = -1; out_last = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        v_i = 1; a = $urandom; b = $urandom;
        op = 2'($urandom_range(0, 3));
      end else begin
        v_i = 0;
      end
      cycle();
    end
    chk("stream accepts", acc, 20);
    chk("stream results", got, 20);
    chk("stream fill latency", out_first - acc_first, 5);
    chk("stream one per cycle", out_last - out_first, 19);
    chk("stream queue empty", expq.size(), 0);

    // Consumer stalled while the producer keeps pushing.
    ordy = 0; acc = 0; got = 0;
    for (int c = 0; c < 10; c++) begin
      v_i = 1; a = $urandom; b = $urandom;
      op = 2'($urandom_range(0, 3));
      cycle();
    end
    chk("stall accepts", acc, 5);
    chk("stall in_ready low", r_o, 0);
    chk("stall out_valid held", ov, 1);
    chk("stall queue depth", expq.size(), 5);
    v_i = 0; ordy = 1;
    for (int c = 0; c < 10; c++) cycle();
    chk("drain results", got, 5);
    chk("drain queue empty", expq.size(), 0);

    // Reset with three requests in flight.
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      v_i = 1; a = $urandom | 32'h1; b = $urandom;
      op = 2'($urandom_range(0, 3));
      cycle();
    end
    v_i = 0;
    chk("inflight accepts", acc, 3);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", ov, 0);
    chk("mid reset out_result", res, 0);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after mid reset", r_o, 1);
    got = 0;
    for (int c = 0; c < 10; c++) cycle();
    chk("no stale results", got, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
